ex_stage: RTL and testbench

RV32I execute stage. Sits between decode (ID) and memory (MEM).
- Accepts one decoded instruction per handshake.
- Resolves operand forwarding from MEM/WB and selects ALU operands.
- Drives one instance of the existing combinational alu; resolves branches/jumps.
- Registers result, store data and control into an EX/MEM pipeline register with valid/ready flow control.

---
 rtl/ex_stage_pkg.sv | 40 ++++
 rtl/alu.sv | 38 +++
 rtl/fwd_mux.sv | 31 +++
 rtl/ex_stage.sv | 167 ++++++++++++++++
 tb/tb_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the RV32I execute stage:
// datapath width, ALU op codes, branch classes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ex_stage_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;

  localparam logic [5:0] OP_ALU_ADD  = 6'd0;
  localparam logic [5:0] OP_ALU_SUB  = 6'd1;
  localparam logic [5:0] OP_ALU_SLL  = 6'd2;
  localparam logic [5:0] OP_ALU_SLT  = 6'd3;
  localparam logic [5:0] OP_ALU_SLTU = 6'd4;
  localparam logic [5:0] OP_ALU_XOR  = 6'd5;
  localparam logic [5:0] OP_ALU_SRL  = 6'd6;
  localparam logic [5:0] OP_ALU_SRA  = 6'd7;
  localparam logic [5:0] OP_ALU_OR   = 6'd8;
  localparam logic [5:0] OP_ALU_AND  = 6'd9;
  localparam logic [5:0] OP_ALU_PASB = 6'd10;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JAL  = 3'd7
  } br_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] br_target;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU.
// Unknown op codes produce zero.
module alu
  import ex_stage_pkg::*;
(
  input  logic [5:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  logic [4:0] sh;
  logic       lt_s;
  logic       lt_u;

  assign sh   = b[4:0];
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    y = '0;
    unique case (1'b1)
      (op == OP_ALU_ADD):  y = a + b;
      (op == OP_ALU_SUB):  y = a - b;
      (op == OP_ALU_SLL):  y = a << sh;
      (op == OP_ALU_SLT):  y = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      (op == OP_ALU_SLTU): y = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      (op == OP_ALU_XOR):  y = a ^ b;
      (op == OP_ALU_SRL):  y = a >> sh;
      (op == OP_ALU_SRA):  y = $unsigned($signed(a) >>> sh);
      (op == OP_ALU_OR):   y = a | b;
      (op == OP_ALU_AND):  y = a & b;
      (op == OP_ALU_PASB): y = b;
      default:             y = '0;
    endcase
  end

endmodule

// File: rtl/fwd_mux.sv
// Operand bypass: MEM beats WB beats register file.
// x0 always reads the register-file value.
module fwd_mux
  import ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  logic nz;
  logic mem_hit;
  logic wb_hit;

  assign nz      = |rs_addr;
  assign mem_hit = mem_we & nz & (mem_rd == rs_addr);
  assign wb_hit  = wb_we & nz & (wb_rd == rs_addr);

  assign fwd_data = mem_hit ? mem_data :
                    wb_hit  ? wb_data  :
                              rf_data;

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: bypass, ALU, branch resolve,
// and the EX/MEM register with valid/ready flow control.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  output logic                  o_id_ready,
  input  logic [5:0]            i_id_alu_op,
  input  logic [DATA_WIDTH-1:0] i_id_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_id_rs2_data,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_id_imm,
  input  logic [DATA_WIDTH-1:0] i_id_pc,
  input  logic                  i_id_use_imm,
  input  logic                  i_id_use_pc,
  input  logic                  i_id_rd_we,
  input  logic [2:0]            i_id_br_type,
  input  logic                  i_mem_fwd_we,
  input  logic                  i_wb_fwd_we,
  input  logic [REG_ADDR_W-1:0] i_mem_fwd_rd,
  input  logic [REG_ADDR_W-1:0] i_wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_fwd_data,
  input  logic [DATA_WIDTH-1:0] i_wb_fwd_data,
  input  logic                  i_flush,
  output logic                  o_ex_valid,
  input  logic                  i_ex_ready,
  output logic [DATA_WIDTH-1:0] o_ex_result,
  output logic [DATA_WIDTH-1:0] o_ex_store_data,
  output logic [REG_ADDR_W-1:0] o_ex_rd_addr,
  output logic                  o_ex_rd_we,
  output logic                  o_br_taken,
  output logic [DATA_WIDTH-1:0] o_br_target
);

  logic [DATA_WIDTH-1:0] rs1_f;
  logic [DATA_WIDTH-1:0] rs2_f;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_y;
  logic [DATA_WIDTH-1:0] pc4;
  logic [DATA_WIDTH-1:0] tgt_base;
  logic [DATA_WIDTH-1:0] tgt_sum;
  logic [DATA_WIDTH-1:0] tgt;
  logic [DATA_WIDTH-1:0] result;
  br_t                   br;
  logic                  is_jal;
  logic                  is_jalr;
  logic                  taken;
  logic                  accept;

  ex_mem_t               q;
  logic                  valid_q;
  logic                  we_q;
  logic                  br_q;
  logic [REG_ADDR_W-1:0] rd_q;

  fwd_mux #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_addr  (i_id_rs1_addr),
    .rf_data  (i_id_rs1_data),
    .mem_we   (i_mem_fwd_we),
    .mem_rd   (i_mem_fwd_rd),
    .mem_data (i_mem_fwd_data),
    .wb_we    (i_wb_fwd_we),
    .wb_rd    (i_wb_fwd_rd),
    .wb_data  (i_wb_fwd_data),
    .fwd_data (rs1_f)
  );

  fwd_mux #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_addr  (i_id_rs2_addr),
    .rf_data  (i_id_rs2_data),
    .mem_we   (i_mem_fwd_we),
    .mem_rd   (i_mem_fwd_rd),
    .mem_data (i_mem_fwd_data),
    .wb_we    (i_wb_fwd_we),
    .wb_rd    (i_wb_fwd_rd),
    .wb_data  (i_wb_fwd_data),
    .fwd_data (rs2_f)
  );

  assign op_a = i_id_use_pc  ? i_id_pc  : rs1_f;
  assign op_b = i_id_use_imm ? i_id_imm : rs2_f;

  alu u_alu (
    .op (i_id_alu_op),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  assign br      = br_t'(i_id_br_type);
  assign is_jal  = (br == BR_JAL);
  // JALR is JAL with the base taken from rs1
  assign is_jalr = is_jal & ~i_id_use_pc;

  always_comb begin
    taken = 1'b0;
    case (br)
      BR_BEQ:  taken = (rs1_f == rs2_f);
      BR_BNE:  taken = (rs1_f != rs2_f);
      BR_BLT:  taken = ($signed(rs1_f) < $signed(rs2_f));
      BR_BGE:  taken = ($signed(rs1_f) >= $signed(rs2_f));
      BR_BLTU: taken = (rs1_f < rs2_f);
      BR_BGEU: taken = (rs1_f >= rs2_f);
      BR_JAL:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign pc4      = i_id_pc + DATA_WIDTH'(4);
  assign tgt_base = is_jalr ? rs1_f : i_id_pc;
  assign tgt_sum  = tgt_base + i_id_imm;

  always_comb begin
    tgt = tgt_sum;
    if (br == BR_NONE)
      tgt = '0;
    else if (is_jalr)
      tgt = {tgt_sum[DATA_WIDTH-1:1], 1'b0};
  end

  assign result = is_jal ? pc4 : alu_y;

  assign o_id_ready = ~valid_q | i_ex_ready;
  assign accept     = i_id_valid & o_id_ready & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      q       <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      br_q    <= 1'b0;
      rd_q    <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      br_q    <= 1'b0;
    end else if (accept) begin
      q.result     <= result;
      q.store_data <= rs2_f;
      q.br_target  <= tgt;
      valid_q      <= 1'b1;
      we_q         <= i_id_rd_we;
      br_q         <= taken;
      rd_q         <= i_id_rd_addr;
    end else if (i_ex_ready) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      br_q    <= 1'b0;
    end
  end

  assign o_ex_valid      = valid_q;
  assign o_ex_result     = q.result;
  assign o_ex_store_data = q.store_data;
  assign o_ex_rd_addr    = rd_q;
  assign o_ex_rd_we      = we_q;
  assign o_br_taken      = br_q;
  assign o_br_target     = q.br_target;

endmodule

// File: tb/tb_ex_stage.sv
// Directed plus random checks of ex_stage against
// an instruction-level reference model.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [5:0]  alu_op;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        use_imm, use_pc, rd_we;
  logic [2:0]  br_type;
  logic        mem_we, wb_we;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result, ex_sd, br_target;
  logic [4:0]  ex_rd;
  logic        ex_we, br_taken;

  int total = 0;
  int bad   = 0;

  logic        m_valid = 1'b0;
  logic        m_we    = 1'b0;
  logic        m_br    = 1'b0;
  logic        m_rst   = 1'b0;
  logic [31:0] m_res, m_sd, m_tgt;
  logic [4:0]  m_rd;
  logic [31:0] saved;

  always #5 clk = ~clk;

  ex_stage dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_id_valid      (id_valid),
    .o_id_ready      (id_ready),
    .i_id_alu_op     (alu_op),
    .i_id_rs1_data   (rs1_data),
    .i_id_rs2_data   (rs2_data),
    .i_id_rs1_addr   (rs1_addr),
    .i_id_rs2_addr   (rs2_addr),
    .i_id_rd_addr    (rd_addr),
    .i_id_imm        (imm),
    .i_id_pc         (pc),
    .i_id_use_imm    (use_imm),
    .i_id_use_pc     (use_pc),
    .i_id_rd_we      (rd_we),
    .i_id_br_type    (br_type),
    .i_mem_fwd_we    (mem_we),
    .i_wb_fwd_we     (wb_we),
    .i_mem_fwd_rd    (mem_rd),
    .i_wb_fwd_rd     (wb_rd),
    .i_mem_fwd_data  (mem_data),
    .i_wb_fwd_data   (wb_data),
    .i_flush         (flush),
    .o_ex_valid      (ex_valid),
    .i_ex_ready      (ex_ready),
    .o_ex_result     (ex_result),
    .o_ex_store_data (ex_sd),
    .o_ex_rd_addr    (ex_rd),
    .o_ex_rd_we      (ex_we),
    .o_br_taken      (br_taken),
    .o_br_target     (br_target)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a,
                                      input logic [31:0] rf);
    if (a == 5'd0) return rf;
    if (mem_we && mem_rd == a) return mem_data;
    if (wb_we && wb_rd == a) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    longint sx, sy;
    sa = int'(b % 32);
    sx = longint'($signed(a));
    sy = longint'($signed(b));
    case (op)
      OP_ALU_ADD:  return a + b;
      OP_ALU_SUB:  return a - b;
      OP_ALU_SLL:  return a << sa;
      OP_ALU_SLT:  return (sx < sy) ? 32'd1 : 32'd0;
      OP_ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_ALU_XOR:  return a ^ b;
      OP_ALU_SRL:  return a >> sa;
      OP_ALU_SRA:  return 32'(sx / (64'sd1 <<< sa) -
                     ((sx < 0 && (sx % (64'sd1 <<< sa)) != 0) ? 1 : 0));
      OP_ALU_OR:   return a | b;
      OP_ALU_AND:  return a & b;
      OP_ALU_PASB: return b;
      default:     return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] bt,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    longint sx, sy;
    sx = longint'($signed(a));
    sy = longint'($signed(b));
    case (bt)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return sx < sy;
      3'd4: return sx >= sy;
      3'd5: return a < b;
      3'd6: return a >= b;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    rst = 0; id_valid = 0; alu_op = OP_ALU_ADD;
    rs1_data = 0; rs2_data = 0; imm = 0; pc = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    use_imm = 0; use_pc = 0; rd_we = 0; br_type = 0;
    mem_we = 0; wb_we = 0; mem_rd = 0; wb_rd = 0;
    mem_data = 0; wb_data = 0; flush = 0; ex_ready = 1;
  endtask

  task automatic cyc();
    logic [31:0] r1, r2, a, b, res, tgt;
    logic        tk, rdy, acc;
    #1;
    rdy = !m_valid || ex_ready;
    if (!rst) chk("id_ready", {31'd0, id_ready}, {31'd0, rdy});
    r1  = fwd(rs1_addr, rs1_data);
    r2  = fwd(rs2_addr, rs2_data);
    a   = use_pc ? pc : r1;
    b   = use_imm ? imm : r2;
    res = (br_type == 3'd7) ? pc + 32'd4 : ref_alu(alu_op, a, b);
    tk  = ref_taken(br_type, r1, r2);
    if (br_type == 3'd0) tgt = 32'd0;
    else if (br_type == 3'd7 && !use_pc) tgt = (r1 + imm) & 32'hFFFF_FFFE;
    else tgt = pc + imm;
    acc = id_valid && rdy && !flush;
    @(posedge clk);
    m_rst = rst;
    if (rst) begin
      m_valid = 0; m_we = 0; m_br = 0;
      m_res = 0; m_sd = 0; m_tgt = 0; m_rd = 0;
    end else if (flush) begin
      m_valid = 0; m_we = 0; m_br = 0;
    end else if (acc) begin
      m_valid = 1; m_we = rd_we; m_br = tk;
      m_res = res; m_sd = r2; m_tgt = tgt; m_rd = rd_addr;
    end else if (ex_ready) begin
      m_valid = 0; m_we = 0; m_br = 0;
    end
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("rd_we", {31'd0, ex_we}, {31'd0, m_we});
    chk("br_taken", {31'd0, br_taken}, {31'd0, m_br});
    if (m_valid || m_rst) begin
      chk("result", ex_result, m_res);
      chk("store_data", ex_sd, m_sd);
      chk("br_target", br_target, m_tgt);
      chk("rd_addr", {27'd0, ex_rd}, {27'd0, m_rd});
    end
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_result", ex_result, 32'd0);
    chk("rst_target", br_target, 32'd0);
    rst = 0;
    #1;
    chk("rdy_after_rst", {31'd0, id_ready}, 32'd1);

    id_valid = 1; rs1_addr = 1; rs1_data = 5; imm = 7;
    use_imm = 1; rd_addr = 4; rd_we = 1;
    cyc();
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_result", ex_result, 32'd12);

    rs1_addr = 3; rs1_data = 32'h99; imm = 0;
    mem_we = 1; mem_rd = 3; mem_data = 32'h10;
    wb_we = 1; wb_rd = 3; wb_data = 32'h20;
    cyc();
    chk("fwd_mem_prio", ex_result, 32'h10);
    mem_we = 0;
    cyc();
    chk("fwd_wb", ex_result, 32'h20);
    mem_we = 1; rs1_addr = 0; rs1_data = 32'h55;
    mem_rd = 0; wb_rd = 0;
    cyc();
    chk("fwd_x0", ex_result, 32'h55);
    mem_we = 0; wb_we = 0;

    rs1_addr = 1; rs1_data = 1; imm = 2;
    cyc();
    saved = ex_result;
    chk("bp_load", saved, 32'd3);
    ex_ready = 0; rs1_data = 100;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold", ex_result, saved);
      chk("bp_ready_low", {31'd0, id_ready}, 32'd0);
    end
    ex_ready = 1;
    cyc();
    chk("bp_release", ex_result, 32'd102);

    rs1_addr = 1; rs2_addr = 2; rs1_data = 32'hFFFF_FFFF;
    rs2_data = 1; pc = 32'h100; imm = 32'h20;
    use_pc = 1; use_imm = 1; rd_we = 0; br_type = 3'd3;
    cyc();
    chk("blt_taken", {31'd0, br_taken}, 32'd1);
    chk("blt_target", br_target, 32'h120);
    br_type = 3'd5;
    cyc();
    chk("bltu_taken", {31'd0, br_taken}, 32'd0);

    rs1_data = 32'h203; imm = 4; pc = 32'h40; use_pc = 0;
    br_type = 3'd7; rd_we = 1; rd_addr = 1;
    cyc();
    chk("jalr_target", br_target, 32'h206);
    chk("jalr_result", ex_result, 32'h44);
    chk("jalr_rd_we", {31'd0, ex_we}, 32'd1);

    flush = 1;
    cyc();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_br", {31'd0, br_taken}, 32'd0);
    flush = 0; br_type = 0; use_pc = 0;

    cyc();
    ex_ready = 0;
    cyc();
    rst = 1;
    cyc();
    chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall_res", ex_result, 32'd0);
    chk("rst_stall_we", {31'd0, ex_we}, 32'd0);
    rst = 0; ex_ready = 1;

    for (int n = 0; n < 500; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      alu_op   = 6'($urandom_range(0, 10));
      rs1_data = $urandom;
      rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : $urandom;
      rs1_addr = 5'($urandom_range(0, 3));
      rs2_addr = 5'($urandom_range(0, 3));
      rd_addr  = 5'($urandom);
      imm      = $urandom;
      pc       = $urandom;
      use_imm  = 1'($urandom);
      use_pc   = 1'($urandom);
      rd_we    = 1'($urandom);
      br_type  = 3'($urandom);
      mem_we   = 1'($urandom);
      wb_we    = 1'($urandom);
      mem_rd   = 5'($urandom_range(0, 3));
      wb_rd    = 5'($urandom_range(0, 3));
      mem_data = $urandom;
      wb_data  = $urandom;
      flush    = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 59) == 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
